congestion_presel_scheduler: RTL and testbench

//  Central scheduler that computes the 4-bit port pre-selection for every router of an NX*NY mesh/torus

---
 rtl/noc_presel_pkg.sv | 24 ++
 rtl/presel_quadrant_cmp.sv | 32 +++
 rtl/congestion_presel_scheduler.sv | 105 ++++++++++
 tb/tb_congestion_presel_scheduler.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/noc_presel_pkg.sv
// Shared constants and helpers for the congestion pre-selection scheduler.
package noc_presel_pkg;

  localparam int P_SELw = 4;

  // Quadrant bit positions inside one node's pre-selection nibble
  localparam int Q_NE = 0;
  localparam int Q_NW = 1;
  localparam int Q_SE = 2;
  localparam int Q_SW = 3;

  function automatic int cong_w(input int congestion_index);
    case (congestion_index)
      3, 5, 7, 9, 12: return 3;
      10:             return 4;
      default:        return 2;
    endcase
  endfunction

  function automatic int CORE_NUM(input int x, input int y, input int nx);
    return y * nx + x;
  endfunction

endpackage

// File: rtl/presel_quadrant_cmp.sv
// One X/Y congestion compare for a quadrant bit; ties (and, with PRESEL_HYST_EN,
// differences within HYST) keep the previous selection.
module presel_quadrant_cmp #(
  parameter int CONGw = 2,
  parameter int HYST  = 1
) (
  input  logic [CONGw-1:0] cong_x,
  input  logic [CONGw-1:0] cong_y,
  input  logic             prev,
  output logic             sel_y
);

`ifdef PRESEL_HYST_EN
  localparam int HYST_EFF = HYST;
`else
  localparam int HYST_EFF = 0;
`endif

  logic [CONGw:0] ext_x, ext_y, diff, thr;

  assign ext_x = {1'b0, cong_x};
  assign ext_y = {1'b0, cong_y};
  assign thr   = (CONGw+1)'(HYST_EFF);
  assign diff  = (ext_x > ext_y) ? ext_x - ext_y : ext_y - ext_x;

  // A zero threshold degenerates to plain strict compare with tie-hold
  always_comb begin
    sel_y = prev;
    if (diff > thr) sel_y = (ext_y < ext_x);
  end

endmodule

// File: rtl/congestion_presel_scheduler.sv
// Round-robin 2-stage scheduler computing per-router quadrant port pre-selection.
// Optional hysteresis on the compare via `define PRESEL_HYST_EN.
module congestion_presel_scheduler
  import noc_presel_pkg::*;
#(
  parameter int    NX               = 2,
  parameter int    NY               = 2,
  parameter string TOPOLOGY         = "MESH",
  parameter int    CONGESTION_INDEX = 2,
  parameter int    HYST             = 1
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      enable,
  input  logic [cong_w(CONGESTION_INDEX)*NX*NY-1:0] congestion_in_all,
  output logic [P_SELw*NX*NY-1:0]                   port_presel_all,
  output logic [$clog2(NX*NY)-1:0]                  scan_node,
  output logic                                      scan_done
);

  localparam int CONGw = cong_w(CONGESTION_INDEX);
  localparam int NC    = NX * NY;
  localparam int SNw   = $clog2(NC);
  localparam bit IS_TORUS = (TOPOLOGY == "TORUS");
  localparam logic [CONGw-1:0] CONG_MAX = '1;
  localparam logic [SNw-1:0]   LAST     = SNw'(NC - 1);

  localparam int D_E = 0;
  localparam int D_W = 1;
  localparam int D_N = 2;
  localparam int D_S = 3;

  function automatic logic [SNw-1:0] node_idx(input int x, input int y);
    return SNw'(CORE_NUM(x, y, NX));
  endfunction

  logic [NC-1:0][CONGw-1:0]  cong_arr;
  logic [NC-1:0][P_SELw-1:0] presel_q;
  logic [3:0][CONGw-1:0]     nb_lvl, s1_lvl;
  logic [SNw-1:0]            s1_node;
  logic                      s1_vld;
  logic [P_SELw-1:0][CONGw-1:0] q_x, q_y;
  logic [P_SELw-1:0]         prev_bits, next_bits;

  assign cong_arr        = congestion_in_all;
  assign port_presel_all = presel_q;

  // Missing mesh neighbours read as saturated so the existing port always wins
  always_comb begin : nb_mux
    int x, y;
    x = int'(scan_node) % NX;
    y = int'(scan_node) / NX;
    nb_lvl = {4{CONG_MAX}};
    if (x < NX-1)      nb_lvl[D_E] = cong_arr[node_idx(x+1, y)];
    else if (IS_TORUS) nb_lvl[D_E] = cong_arr[node_idx(0, y)];
    if (x > 0)         nb_lvl[D_W] = cong_arr[node_idx(x-1, y)];
    else if (IS_TORUS) nb_lvl[D_W] = cong_arr[node_idx(NX-1, y)];
    if (y > 0)         nb_lvl[D_N] = cong_arr[node_idx(x, y-1)];
    else if (IS_TORUS) nb_lvl[D_N] = cong_arr[node_idx(x, NY-1)];
    if (y < NY-1)      nb_lvl[D_S] = cong_arr[node_idx(x, y+1)];
    else if (IS_TORUS) nb_lvl[D_S] = cong_arr[node_idx(x, 0)];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_node <= '0;
      s1_vld    <= 1'b0;
      s1_node   <= '0;
      s1_lvl    <= '0;
    end else begin
      s1_vld <= enable;
      if (enable) begin
        s1_node   <= scan_node;
        s1_lvl    <= nb_lvl;
        scan_node <= (scan_node == LAST) ? '0 : scan_node + SNw'(1);
      end
    end
  end

  assign q_x[Q_NE] = s1_lvl[D_E];  assign q_y[Q_NE] = s1_lvl[D_N];
  assign q_x[Q_NW] = s1_lvl[D_W];  assign q_y[Q_NW] = s1_lvl[D_N];
  assign q_x[Q_SE] = s1_lvl[D_E];  assign q_y[Q_SE] = s1_lvl[D_S];
  assign q_x[Q_SW] = s1_lvl[D_W];  assign q_y[Q_SW] = s1_lvl[D_S];
  assign prev_bits = presel_q[s1_node];

  for (genvar q = 0; q < P_SELw; q++) begin : g_cmp
    presel_quadrant_cmp #(.CONGw(CONGw), .HYST(HYST)) u_cmp (
      .cong_x (q_x[q]),
      .cong_y (q_y[q]),
      .prev   (prev_bits[q]),
      .sel_y  (next_bits[q])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presel_q  <= '0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= s1_vld && (s1_node == LAST);
      if (s1_vld) presel_q[s1_node] <= next_bits;
    end
  end

endmodule

// File: tb/tb_congestion_presel_scheduler.sv
// Directed bench: 2x2 mesh scheduler plus a 3x3 torus instance sharing clock/reset/enable.
module tb_congestion_presel_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  cong;
  logic [15:0] presel;
  logic [1:0]  scan_node;
  logic        scan_done;
  logic [17:0] cong_t;
  logic [35:0] presel_t;
  logic [3:0]  scan_node_t;
  logic        scan_done_t;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  congestion_presel_scheduler #(.NX(2), .NY(2), .TOPOLOGY("MESH"), .CONGESTION_INDEX(2), .HYST(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .congestion_in_all(cong),
    .port_presel_all(presel), .scan_node(scan_node), .scan_done(scan_done));

  congestion_presel_scheduler #(.NX(3), .NY(3), .TOPOLOGY("TORUS"), .CONGESTION_INDEX(2), .HYST(1)) dut_t (
    .clk(clk), .reset(reset), .enable(enable), .congestion_in_all(cong_t),
    .port_presel_all(presel_t), .scan_node(scan_node_t), .scan_done(scan_done_t));

  typedef struct {
    logic [7:0]  cong;   // {c3,c2,c1,c0}
    logic [15:0] exp;    // {n3,n2,n1,n0}
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_scans(input int n, input bit torus);
    int seen = 0;
    int c = 0;
    while (seen < n && c < 200) begin
      tick();
      c++;
      if (torus ? scan_done_t : scan_done) seen++;
    end
    chk(torus ? "scan_budget_t" : "scan_budget", 64'(seen), 64'(n));
  endtask

  // Called right after releasing reset with cong = 8'hCC
  task automatic release_check(input string tag);
    int first = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 1) chk({tag, "_n0_pre"}, 64'(presel[3:0]), 64'h0);
      if (n == 2) chk({tag, "_n0_lat2"}, 64'(presel[3:0]), 64'hC);
      if (scan_done) begin
        first = n;
        break;
      end
    end
    chk({tag, "_first_done"}, 64'(first), 64'd5);
  endtask

  initial begin
    int  found;
    bit  done_seen;

    tbl[0] = '{8'hCC, 16'h030C};
    tbl[1] = '{8'h33, 16'h32C8};
    tbl[2] = '{8'hFF, 16'h32C8};
    tbl[3] = '{8'h00, 16'h32C8};
    tbl[4] = '{8'hF0, 16'h3348};
    tbl[5] = '{8'h0F, 16'h12CC};

    for (int i = 0; i < 9; i++) cong_t[2*i +: 2] = (i == 6) ? 2'd0 : 2'd1;
    cong   = 8'hCC;
    enable = 1'b1;
    reset  = 1'b0;

    #12;
    chk("rst_presel", 64'(presel), 64'h0);
    chk("rst_scan_node", 64'(scan_node), 64'h0);
    chk("rst_scan_done", 64'(scan_done), 64'h0);
    chk("rst_presel_t", 64'(presel_t), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    release_check("rel1");

    foreach (tbl[i]) begin
      cong = tbl[i].cong;
      wait_scans(2, 1'b0);
      chk($sformatf("vec%0d", i), 64'(presel), 64'(tbl[i].exp));
    end

    // Freeze at scan_node==2 with node1 just sampled under new levels
    found = 0;
    for (int c = 0; c < 20; c++) begin
      if (scan_node == 2'd1) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("find_node1", 64'(found), 64'd1);
    cong = 8'hCC;
    tick();
    chk("at_node2", 64'(scan_node), 64'd2);
    enable = 1'b0;
    done_seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("frozen_idx", 64'(scan_node), 64'd2);
      done_seen |= scan_done;
    end
    chk("frozen_no_done", 64'(done_seen), 64'd0);
    chk("frozen_n1_written", 64'(presel[7:4]), 64'h4);
    chk("frozen_n2_held", 64'(presel[11:8]), 64'h2);
    enable = 1'b1;
    tick();
    chk("resume_idx", 64'(scan_node), 64'd3);
    tick();
    chk("resume_n2", 64'(presel[11:8]), 64'h3);
    wait_scans(2, 1'b0);
    chk("resume_full", 64'(presel), 64'h134C);

    // Asynchronous reset in the middle of a cycle
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("mid_rst_presel", 64'(presel), 64'h0);
    chk("mid_rst_scan_node", 64'(scan_node), 64'h0);
    chk("mid_rst_scan_done", 64'(scan_done), 64'h0);
    chk("mid_rst_presel_t", 64'(presel_t), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    release_check("rel2");

    // Edge node1: SW set by W=3,S=0, then held on W=S=2 tie
    cong = 8'h33;
    wait_scans(2, 1'b0);
    chk("n1_sw_set", 64'(presel[7]), 64'd1);
    cong = 8'hB2;
    wait_scans(2, 1'b0);
    chk("n1_sw_tie_hold", 64'(presel[7]), 64'd1);

    // Node2 NE (E=node3 vs N=node0): diff 1 then diff 2
    cong = 8'hB1;
    wait_scans(2, 1'b0);
`ifdef PRESEL_HYST_EN
    chk("n2_ne_diff1", 64'(presel[8]), 64'd0);
`else
    chk("n2_ne_diff1", 64'(presel[8]), 64'd1);
`endif
    cong = 8'hF1;
    wait_scans(2, 1'b0);
    chk("n2_ne_diff2", 64'(presel[8]), 64'd1);

    // Torus 3x3: index wrap and wrapped neighbours
    found = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (scan_node_t == 4'd8) begin
        found = 1;
        break;
      end
    end
    chk("torus_find_8", 64'(found), 64'd1);
    tick();
    chk("torus_wrap", 64'(scan_node_t), 64'd0);
    wait_scans(2, 1'b1);
`ifdef PRESEL_HYST_EN
    chk("torus_presel", 64'(presel_t), 64'h0);
`else
    chk("torus_presel", 64'(presel_t), 64'h0_0000_C003);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
